ball_ctrl: RTL and testbench

BALL_CTRL -- requirements
Module: ball_ctrl

---
 rtl/ball_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_ball_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ball_ctrl.sv
// Ball motion, paddle collision, scoring and serve control for a two-player
// paddle game. All game-state changes happen once per frame, on the tick
// derived from the falling edge of vsync. The ball pixel is decoded
// combinationally from the registered ball position.
module ball_ctrl #(
  parameter int HOLD_FRAMES = 32,  // frames the ball stays hidden after a point
  parameter int WIN_SCORE   = 9    // score that ends the game
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic [8:0] paddle_pos_l,
  input  logic [8:0] paddle_pos_r,
  input  logic       serve_n,
  output logic [9:0] ball_x,
  output logic [8:0] ball_y,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       point_l,
  output logic       point_r,
  output logic       game_over,
  output logic       r,
  output logic       g,
  output logic       b
);

  localparam int HW = (HOLD_FRAMES < 2) ? 1 : $clog2(HOLD_FRAMES + 1);

  localparam logic [9:0] HOME_X = 10'd316;
  localparam logic [8:0] HOME_Y = 9'd236;

  typedef enum logic [1:0] {SERVE, PLAY, SCORED, GAME_OVER} state_t;

  state_t         state_reg;
  logic           vsync_reg;
  logic [9:0]     ball_x_reg;
  logic [8:0]     ball_y_reg;
  logic           dir_x_reg;      // 1 = moving right
  logic           dir_y_reg;      // 1 = moving down
  logic           serve_dir_reg;  // direction of the next serve, 1 = right
  logic [3:0]     score_l_reg;
  logic [3:0]     score_r_reg;
  logic           point_l_reg;
  logic           point_r_reg;
  logic [HW-1:0]  hold_reg;

  // Frame tick: vsync was high last clock and is low now.
  logic tick;
  assign tick = vsync_reg & ~vsync;

  // Collision arithmetic is done in 10 bits so paddle_pos+48 never wraps.
  logic [9:0] y_top, y_bot, pad_l_top, pad_l_bot, pad_r_top, pad_r_bot;
  logic       hit_l, hit_r, miss_l, miss_r;
  logic [3:0] score_l_inc, score_r_inc;

  assign y_top     = {1'b0, ball_y_reg};
  assign y_bot     = y_top + 10'd7;
  assign pad_l_top = {1'b0, paddle_pos_l};
  assign pad_l_bot = pad_l_top + 10'd48;
  assign pad_r_top = {1'b0, paddle_pos_r};
  assign pad_r_bot = pad_r_top + 10'd48;

  assign hit_l  = !dir_x_reg && (ball_x_reg >= 10'd24) && (ball_x_reg < 10'd28) &&
                  (y_bot >= pad_l_top) && (y_top <= pad_l_bot);
  assign hit_r  = dir_x_reg && (ball_x_reg >= 10'd608) && (ball_x_reg < 10'd612) &&
                  (y_bot >= pad_r_top) && (y_top <= pad_r_bot);
  assign miss_l = !dir_x_reg && (ball_x_reg < 10'd4);
  assign miss_r = dir_x_reg && (ball_x_reg >= 10'd632);

  assign score_l_inc = score_l_reg + 4'd1;
  assign score_r_inc = score_r_reg + 4'd1;

  // Game state machine; everything except vsync sampling and the point pulses waits for tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= SERVE;
      vsync_reg     <= 1'b0;
      ball_x_reg    <= HOME_X;
      ball_y_reg    <= HOME_Y;
      dir_x_reg     <= 1'b1;
      dir_y_reg     <= 1'b1;
      serve_dir_reg <= 1'b1;
      score_l_reg   <= 4'd0;
      score_r_reg   <= 4'd0;
      point_l_reg   <= 1'b0;
      point_r_reg   <= 1'b0;
      hold_reg      <= '0;
    end else begin
      vsync_reg   <= vsync;
      point_l_reg <= 1'b0;
      point_r_reg <= 1'b0;
      if (tick) begin
        case (state_reg)
          SERVE: begin
            if (!serve_n) begin
              state_reg <= PLAY;
              dir_x_reg <= serve_dir_reg;
              dir_y_reg <= 1'b1;
            end
          end
          PLAY: begin
            if (miss_l) begin
              // Right scores; the left player lost, so serve toward the left.
              score_r_reg   <= score_r_inc;
              point_r_reg   <= 1'b1;
              hold_reg      <= HW'(HOLD_FRAMES);
              serve_dir_reg <= 1'b0;
              state_reg     <= (score_r_inc == 4'(WIN_SCORE)) ? GAME_OVER : SCORED;
            end else if (miss_r) begin
              score_l_reg   <= score_l_inc;
              point_l_reg   <= 1'b1;
              hold_reg      <= HW'(HOLD_FRAMES);
              serve_dir_reg <= 1'b1;
              state_reg     <= (score_l_inc == 4'(WIN_SCORE)) ? GAME_OVER : SCORED;
            end else begin
              // Horizontal: a paddle hit reverses and steps away in the same tick.
              if (hit_l) begin
                dir_x_reg  <= 1'b1;
                ball_x_reg <= ball_x_reg + 10'd4;
              end else if (hit_r) begin
                dir_x_reg  <= 1'b0;
                ball_x_reg <= ball_x_reg - 10'd4;
              end else if (dir_x_reg) begin
                ball_x_reg <= ball_x_reg + 10'd4;
              end else begin
                ball_x_reg <= ball_x_reg - 10'd4;
              end
              // Vertical: clamp to the wall row and reverse.
              if (dir_y_reg) begin
                if (y_top + 10'd2 >= 10'd456) begin
                  ball_y_reg <= 9'd456;
                  dir_y_reg  <= 1'b0;
                end else begin
                  ball_y_reg <= ball_y_reg + 9'd2;
                end
              end else begin
                if (y_top <= 10'd18) begin
                  ball_y_reg <= 9'd16;
                  dir_y_reg  <= 1'b1;
                end else begin
                  ball_y_reg <= ball_y_reg - 9'd2;
                end
              end
            end
          end
          SCORED: begin
            if (hold_reg <= HW'(1)) begin
              hold_reg   <= '0;
              state_reg  <= SERVE;
              ball_x_reg <= HOME_X;
              ball_y_reg <= HOME_Y;
            end else begin
              hold_reg <= hold_reg - HW'(1);
            end
          end
          GAME_OVER: begin
            if (!serve_n) begin
              score_l_reg   <= 4'd0;
              score_r_reg   <= 4'd0;
              serve_dir_reg <= 1'b1;
              state_reg     <= SERVE;
              ball_x_reg    <= HOME_X;
              ball_y_reg    <= HOME_Y;
            end
          end
          default: state_reg <= SERVE;
        endcase
      end
    end
  end

  // Ball pixel: visible only while serving or in play, inside the 8x8 box.
  logic in_x, in_y, visible;
  assign in_x    = (hcount >= ball_x_reg) &&
                   ({1'b0, hcount} <= ({1'b0, ball_x_reg} + 11'd7));
  assign in_y    = ({1'b0, vcount} >= {2'b00, ball_y_reg}) &&
                   ({1'b0, vcount} <= ({2'b00, ball_y_reg} + 11'd7));
  assign visible = ((state_reg == SERVE) || (state_reg == PLAY)) && in_x && in_y;

  assign r         = visible;
  assign g         = visible;
  assign b         = visible;
  assign ball_x    = ball_x_reg;
  assign ball_y    = ball_y_reg;
  assign score_l   = score_l_reg;
  assign score_r   = score_r_reg;
  assign point_l   = point_l_reg;
  assign point_r   = point_r_reg;
  assign game_over = (state_reg == GAME_OVER);

endmodule

// File: tb/tb_ball_ctrl.sv
// Self-checking bench for ball_ctrl: directed serve/reset checks followed by
// randomized rallies compared against a frame-level behavioural model.
module tb_ball_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       vsync;
  logic [9:0] hcount, vcount;
  logic [8:0] paddle_pos_l, paddle_pos_r;
  logic       serve_n;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic [3:0] score_l, score_r;
  logic       point_l, point_r, game_over;
  logic       r, g, b;

  ball_ctrl #(.HOLD_FRAMES(32), .WIN_SCORE(9)) dut (
    .clk(clk), .rst(rst), .vsync(vsync), .hcount(hcount), .vcount(vcount),
    .paddle_pos_l(paddle_pos_l), .paddle_pos_r(paddle_pos_r), .serve_n(serve_n),
    .ball_x(ball_x), .ball_y(ball_y), .score_l(score_l), .score_r(score_r),
    .point_l(point_l), .point_r(point_r), .game_over(game_over),
    .r(r), .g(g), .b(b)
  );

  always #5 clk = ~clk;

  int test_count = 0;
  int fail_count = 0;

  task automatic check(input string tag, input int obs, input int exp);
    test_count++;
    if (obs != exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Behavioural model: phases by name, ball motion as signed velocities.
  localparam int PH_WAIT = 0, PH_RALLY = 1, PH_HIDDEN = 2, PH_OVER = 3;
  int m_phase, m_x, m_y, m_vx, m_vy, m_sl, m_sr, m_hold, m_serve_vx;
  bit m_pl, m_pr;

  task automatic model_reset();
    m_phase = PH_WAIT; m_x = 316; m_y = 236; m_vx = 4; m_vy = 2;
    m_sl = 0; m_sr = 0; m_pl = 0; m_pr = 0; m_hold = 0; m_serve_vx = 4;
  endtask

  function automatic bit covers(input int y, input int p);
    return (y + 7 >= p) && (y <= p + 48);
  endfunction

  task automatic model_score(input bit right_scores);
    int s;
    if (right_scores) begin
      m_sr++; m_pr = 1; m_serve_vx = -4; s = m_sr;
    end else begin
      m_sl++; m_pl = 1; m_serve_vx = 4; s = m_sl;
    end
    m_hold  = 32;
    m_phase = (s == 9) ? PH_OVER : PH_HIDDEN;
  endtask

  task automatic model_tick();
    bit hit;
    m_pl = 0; m_pr = 0;
    case (m_phase)
      PH_WAIT: if (!serve_n) begin m_phase = PH_RALLY; m_vx = m_serve_vx; m_vy = 2; end
      PH_RALLY: begin
        if (m_vx < 0 && m_x < 4) model_score(1);
        else if (m_vx > 0 && m_x >= 632) model_score(0);
        else begin
          if (m_vx < 0) hit = (m_x >= 24 && m_x < 28 && covers(m_y, int'(paddle_pos_l)));
          else          hit = (m_x >= 608 && m_x < 612 && covers(m_y, int'(paddle_pos_r)));
          if (hit) m_vx = -m_vx;
          m_x += m_vx;
          if (m_vy > 0) begin
            if (m_y + 2 >= 456) begin m_y = 456; m_vy = -2; end else m_y += 2;
          end else begin
            if (m_y <= 18) begin m_y = 16; m_vy = 2; end else m_y -= 2;
          end
        end
      end
      PH_HIDDEN: begin
        m_hold--;
        if (m_hold <= 0) begin m_phase = PH_WAIT; m_x = 316; m_y = 236; end
      end
      default: if (!serve_n) begin
        m_sl = 0; m_sr = 0; m_serve_vx = 4; m_phase = PH_WAIT; m_x = 316; m_y = 236;
      end
    endcase
  endtask

  task automatic check_state(input string tag);
    check({tag, "_x"}, int'(ball_x), m_x);
    check({tag, "_y"}, int'(ball_y), m_y);
    check({tag, "_sl"}, int'(score_l), m_sl);
    check({tag, "_sr"}, int'(score_r), m_sr);
    check({tag, "_pl"}, int'(point_l), int'(m_pl));
    check({tag, "_pr"}, int'(point_r), int'(m_pr));
    check({tag, "_go"}, int'(game_over), int'(m_phase == PH_OVER));
  endtask

  // Probe a pixel near the ball and compare the colour outputs.
  task automatic check_pixel(input string tag);
    int h, v;
    bit exp;
    h = m_x + $urandom_range(0, 12) - 2; if (h < 0) h = 0;
    v = m_y + $urandom_range(0, 12) - 2; if (v < 0) v = 0;
    hcount = 10'(h); vcount = 10'(v);
    #1;
    exp = (m_phase == PH_WAIT || m_phase == PH_RALLY) &&
          (h >= m_x) && (h <= m_x + 7) && (v >= m_y) && (v <= m_y + 7);
    check({tag, "_r"}, int'(r), int'(exp));
    check({tag, "_g"}, int'(g), int'(exp));
    check({tag, "_b"}, int'(b), int'(exp));
  endtask

  // One frame: vsync high for two clocks, then low so the next edge is a tick.
  task automatic frame(input string tag);
    vsync = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vsync = 1'b0;
    model_tick();
    @(posedge clk); #1;
    check_state(tag);
    check_pixel(tag);
    @(posedge clk); #1;
    check({tag, "_pl_end"}, int'(point_l), 0);
    check({tag, "_pr_end"}, int'(point_r), 0);
  endtask

  initial begin
    int p;
    rst = 1'b1; vsync = 1'b0; serve_n = 1'b1;
    hcount = '0; vcount = '0; paddle_pos_l = '0; paddle_pos_r = '0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    check_state("reset");
    check_pixel("reset");

    // Serve to the right and take three steps.
    serve_n = 1'b0;
    frame("serve");
    serve_n = 1'b1;
    repeat (3) frame("step");
    check("step3_x", int'(ball_x), 328);
    check("step3_y", int'(ball_y), 242);

    // vsync held high: no tick, no motion.
    vsync = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("vsync_hold_x", int'(ball_x), 328);
    check("vsync_hold_y", int'(ball_y), 242);

    // Asynchronous reset between clock edges, mid-rally.
    #2;
    rst = 1'b1; vsync = 1'b0;
    #1;
    model_reset();
    check_state("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;

    // Randomized play: paddles either track the ball or sit at random rows.
    for (int i = 0; i < 4000; i++) begin
      serve_n = 1'($urandom_range(0, 1));
      p = ($urandom_range(0, 1) == 0) ? (m_y + 7 - int'($urandom_range(0, 55)))
                                      : int'($urandom_range(0, 511));
      if (p < 0) p = 0; if (p > 511) p = 511;
      paddle_pos_l = 9'(p);
      p = ($urandom_range(0, 1) == 0) ? (m_y + 7 - int'($urandom_range(0, 55)))
                                      : int'($urandom_range(0, 511));
      if (p < 0) p = 0; if (p > 511) p = 511;
      paddle_pos_r = 9'(p);
      frame("rand");
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
